// File: rtl/iter_barrel_shifter.sv
// rtl/iter_barrel_shifter.sv - multi-cycle logarithmic barrel shifter/rotator
//
// Purpose: applies one barrel level (shift by 2^k) per clock to a registered
// work value. Supports SLL, SRL, SRA and ROR behind a start/busy/done handshake.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    request, accepted in IDLE or DONE
//   op       00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled with start
//   data_in  operand; sampled with start
//   shamt    shift amount 0..WIDTH-1; sampled with start
//   busy     high while levels are being applied
//   done     one-cycle pulse, result valid while high
//   result   shifted value, held until the next operation completes

module iter_barrel_shifter #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 0,
  localparam int SHW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [1:0]       op_q;
  logic [SHW-1:0]   shamt_q;
  logic [SHW-1:0]   k;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] level_out;
  logic [SHW-1:0]   upper_bits;
  logic             last_level;
  logic             exit_now;

  // Only the level selected by k is active; each candidate is a constant
  // shift, so this is a small mux rather than a full variable shifter.
  always_comb begin
    shifted = work;
    for (int i = 0; i < SHW; i++) begin
      if (k == SHW'(i)) begin
        case (op_q)
          OP_SLL:  shifted = work << (2 ** i);
          OP_SRL:  shifted = work >> (2 ** i);
          // The work MSB still holds the original sign after earlier SRA levels.
          OP_SRA:  shifted = $unsigned($signed(work) >>> (2 ** i));
          default: shifted = (work >> (2 ** i)) | (work << (WIDTH - 2 ** i));
        endcase
      end
    end
  end

  always_comb begin
    level_out  = shamt_q[k] ? shifted : work;
    // Shamt bits above the current level; all-zero means nothing is left to do.
    upper_bits = shamt_q >> (k + SHW'(1));
    last_level = (k == SHW'(SHW - 1));
    exit_now   = last_level || ((EARLY_EXIT != 0) && (upper_bits == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      work    <= '0;
      op_q    <= '0;
      shamt_q <= '0;
      k       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            work    <= data_in;
            op_q    <= op;
            shamt_q <= shamt;
            k       <= '0;
            if ((EARLY_EXIT != 0) && (shamt == '0)) begin
              state  <= ST_DONE;
              result <= data_in;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          // start is deliberately ignored here: no queueing of requests.
          work <= level_out;
          k    <= k + SHW'(1);
          if (exit_now) begin
            state  <= ST_DONE;
            result <= level_out;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_barrel_shifter.sv
// tb/tb_iter_barrel_shifter.sv - directed self-checking bench for iter_barrel_shifter

module tb_iter_barrel_shifter;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: WIDTH=32, EARLY_EXIT=0
  logic        rst_a, start_a, busy_a, done_a;
  logic [1:0]  op_a;
  logic [31:0] data_a, result_a;
  logic [4:0]  shamt_a;
  // b: WIDTH=32, EARLY_EXIT=1
  logic        rst_b, start_b, busy_b, done_b;
  logic [1:0]  op_b;
  logic [31:0] data_b, result_b;
  logic [4:0]  shamt_b;
  // c: WIDTH=8, EARLY_EXIT=0
  logic        rst_c, start_c, busy_c, done_c;
  logic [1:0]  op_c;
  logic [7:0]  data_c, result_c;
  logic [2:0]  shamt_c;

  iter_barrel_shifter #(.WIDTH(32), .EARLY_EXIT(0)) u_a (
    .clk(clk), .reset(rst_a), .start(start_a), .op(op_a), .data_in(data_a),
    .shamt(shamt_a), .busy(busy_a), .done(done_a), .result(result_a));

  iter_barrel_shifter #(.WIDTH(32), .EARLY_EXIT(1)) u_b (
    .clk(clk), .reset(rst_b), .start(start_b), .op(op_b), .data_in(data_b),
    .shamt(shamt_b), .busy(busy_b), .done(done_b), .result(result_b));

  iter_barrel_shifter #(.WIDTH(8), .EARLY_EXIT(0)) u_c (
    .clk(clk), .reset(rst_c), .start(start_c), .op(op_c), .data_in(data_c),
    .shamt(shamt_c), .busy(busy_c), .done(done_c), .result(result_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [1:0] o,
                       input logic [31:0] d, input logic [4:0] s);
    case (sel)
      0: begin start_a = st; op_a = o; data_a = d; shamt_a = s; end
      1: begin start_b = st; op_b = o; data_b = d; shamt_b = s; end
      default: begin start_c = st; op_c = o; data_c = d[7:0]; shamt_c = s[2:0]; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [31:0] get_result(input int sel);
    case (sel)
      0: return result_a;
      1: return result_b;
      default: return {24'h0, result_c};
    endcase
  endfunction

  // One operation: n counts negedges after the accept edge; done is expected
  // at n == lat, with busy high for every earlier sample.
  task automatic run_op(input int sel, input string tag, input logic [1:0] o,
                        input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp, input int lat);
    int n;
    int busy_cnt;
    @(negedge clk);
    drive(sel, 1'b1, o, d, s);
    @(negedge clk);
    drive(sel, 1'b0, ~o, ~d, ~s);
    n = 1;
    busy_cnt = 0;
    while (!get_done(sel) && n < 40) begin
      if (get_busy(sel)) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, get_result(sel), exp);
    check({tag, "_busy_cnt"}, busy_cnt, lat - 1);
    check({tag, "_busy_at_done"}, {31'h0, get_busy(sel)}, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'h0, get_done(sel)}, 0);
    check({tag, "_held"}, get_result(sel), exp);
  endtask

  initial begin
    int n;
    int done_seen;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    drive(0, 1'b0, SLL, 32'h0, 5'd0);
    drive(1, 1'b0, SLL, 32'h0, 5'd0);
    drive(2, 1'b0, SLL, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy_a}, 0);
    check("rst_done", {31'h0, done_a}, 0);
    check("rst_result", result_a, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Fixed latency L+1 = 6 at WIDTH=32.
    run_op(0, "sra4",  SRA, 32'h80000000, 5'd4,  32'hF8000000, 6);
    run_op(0, "sll31", SLL, 32'h00000001, 5'd31, 32'h80000000, 6);
    run_op(0, "srl28", SRL, 32'hF0000000, 5'd28, 32'h0000000F, 6);
    run_op(0, "ror1",  ROR, 32'h00000001, 5'd1,  32'h80000000, 6);
    run_op(0, "ror0",  ROR, 32'h12345678, 5'd0,  32'h12345678, 6);

    // start pulsed during SHIFT (k=2) must be ignored.
    @(negedge clk);
    drive(0, 1'b1, SRA, 32'h80000000, 5'd31);
    @(negedge clk);
    drive(0, 1'b0, SRA, 32'h80000000, 5'd31);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, SRL, 32'hFFFFFFFF, 5'd8);
    @(negedge clk);
    drive(0, 1'b0, SRL, 32'hFFFFFFFF, 5'd8);
    n = 4;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ign_lat", n, 6);
    check("ign_res", result_a, 32'hFFFFFFFF);

    // start held through the DONE cycle: back-to-back accept, no idle gap.
    drive(0, 1'b1, SRL, 32'hFFFFFFFF, 5'd8);
    @(negedge clk);
    drive(0, 1'b0, SLL, 32'h0, 5'd0);
    check("b2b_busy", {31'h0, busy_a}, 1);
    check("b2b_done_low", {31'h0, done_a}, 0);
    check("b2b_result_held", result_a, 32'hFFFFFFFF);
    n = 1;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_lat", n, 6);
    check("b2b_res", result_a, 32'h00FFFFFF);

    // Asynchronous reset mid-SHIFT (k=3), away from any clock edge.
    @(negedge clk);
    drive(0, 1'b1, SLL, 32'h00000001, 5'd31);
    @(negedge clk);
    drive(0, 1'b0, SLL, 32'h00000001, 5'd31);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy_a}, 1);
    #2 rst_a = 1'b1;
    #1;
    check("arst_busy", {31'h0, busy_a}, 0);
    check("arst_done", {31'h0, done_a}, 0);
    check("arst_result", result_a, 0);
    #1 rst_a = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    check("arst_no_done", done_seen, 0);
    run_op(0, "post_rst", SRA, 32'h80000000, 5'd4, 32'hF8000000, 6);

    // EARLY_EXIT=1: done after highest set shamt bit index + 1 level edges.
    run_op(1, "ee_s0",  SLL, 32'hA5A5A5A5, 5'd0, 32'hA5A5A5A5, 1);
    run_op(1, "ee_s3",  SLL, 32'h00000001, 5'd3, 32'h00000008, 3);
    run_op(1, "ee_sra4", SRA, 32'h80000000, 5'd4, 32'hF8000000, 4);

    // WIDTH=8: three level edges, fixed latency 4.
    run_op(2, "w8_sra7", SRA, 32'h00000090, 5'd7, 32'h000000FF, 4);
    run_op(2, "w8_ror4", ROR, 32'h00000081, 5'd4, 32'h00000018, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
